alu_cmd_master: RTL and testbench

- Host-side command sequencer that drives the operand-load/execute interface of the 8-bit CPU/ALU block, i.e. the initiator end of its ce/load/opcode/data_in protocol.
- Accepts load and execute commands over a valid/ready stream and serialises them into single-cycle ce strobes.
- Honours the CPU's post-execute busy window, samples data_out at the fixed result point, and returns results over a valid/ready result port.

---
 rtl/alu_cmd_master.sv | 191 +++++++++++++++++++
 tb/tb_alu_cmd_master.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_master.sv
// -----------------------------------------------------------------------------
// alu_cmd_master
//
// Host-side command sequencer for the 8-bit CPU/ALU block. Load and execute
// commands arrive on a valid/ready stream and are turned into single-cycle
// ce strobes on the CPU's ce/load/opcode/data_in interface. After an execute
// strobe the sequencer waits out the CPU's busy window, samples data_out on
// the last busy cycle, and presents the result on a valid/ready result port.
//
// Parameters
//   BUSY_CYCLES  cycles the CPU stays busy after an execute strobe (1..15)
//   CNT_W        width of the optional statistics counters
//
// Ports
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_exec                    0 = load operand, 1 = execute
//   cmd_reg, cmd_data           register index, load data
//   cmd_op, cmd_cin, cmd_cout   ALU operation, carry-in, cout control (execute)
//   ce, load, opcode, data_in   registered CPU strobe, load select, opcode, operand
//   cin, cout                   registered carry-in / cout control to the CPU
//   data_out                    CPU result
//   res_valid/res_ready         result handshake
//   res_data                    captured result
//
// Optional feature (macro ALU_CMD_STATS_EN)
//   stat_clr                    synchronous clear of both counters
//   load_cnt, exec_cnt          saturating counts of load / execute strobes
// -----------------------------------------------------------------------------
module alu_cmd_master #(
    parameter int BUSY_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ALU_CMD_STATS_EN
    input  logic             stat_clr,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] exec_cnt,
`endif
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_exec,
    input  logic [2:0]       cmd_reg,
    input  logic [7:0]       cmd_data,
    input  logic [3:0]       cmd_op,
    input  logic             cmd_cin,
    input  logic             cmd_cout,
    output logic             ce,
    output logic             load,
    output logic [7:0]       opcode,
    output logic [7:0]       data_in,
    output logic             cin,
    output logic             cout,
    input  logic [7:0]       data_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_data
);

    // Reject out-of-range configurations at elaboration time.
    if (BUSY_CYCLES < 1 || BUSY_CYCLES > 15) begin : g_bad_busy
        $error("alu_cmd_master: BUSY_CYCLES must be in 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("alu_cmd_master: CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRV_LOAD = 2'd1,
        S_DRV_EXEC = 2'd2,
        S_BUSY     = 2'd3
    } state_e;

    localparam logic [3:0] BUSY_LAST = 4'(BUSY_CYCLES - 1);

    state_e     state_q;
    logic [3:0] busy_cnt_q;
    logic       ce_q;
    logic       load_q;
    logic [7:0] opcode_q;
    logic [7:0] data_in_q;
    logic       cin_q;
    logic       cout_q;
    logic       res_valid_q;
    logic [7:0] res_data_q;
    logic       cmd_accept;

    // A new command may be taken while idle or while a load strobe is on the
    // bus (back-to-back loads), but never while a result is still unread.
    assign cmd_ready  = ((state_q == S_IDLE) || (state_q == S_DRV_LOAD)) && !res_valid_q;
    assign cmd_accept = cmd_valid && cmd_ready;

    // NOTE: state and outputs use non-blocking assignments so every register
    // updates from the values that were present before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_cnt_q  <= 4'd0;
            ce_q        <= 1'b0;
            load_q      <= 1'b0;
            opcode_q    <= 8'h00;
            data_in_q   <= 8'h00;
            cin_q       <= 1'b0;
            cout_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'h00;
        end else begin
            // ce and load are strobes: low unless a command is launched below.
            ce_q   <= 1'b0;
            load_q <= 1'b0;

            if (res_valid_q && res_ready) begin
                res_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE, S_DRV_LOAD: begin
                    if (cmd_accept) begin
                        ce_q <= 1'b1;
                        if (cmd_exec) begin
                            state_q  <= S_DRV_EXEC;
                            opcode_q <= {1'b0, cmd_reg, cmd_op};
                            cin_q    <= cmd_cin;
                            cout_q   <= cmd_cout;
                        end else begin
                            state_q   <= S_DRV_LOAD;
                            load_q    <= 1'b1;
                            opcode_q  <= {1'b0, cmd_reg, 4'h0};
                            data_in_q <= cmd_data;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_DRV_EXEC: begin
                    state_q    <= S_BUSY;
                    busy_cnt_q <= BUSY_LAST;
                end

                S_BUSY: begin
                    // The CPU result is valid on the final busy cycle.
                    if (busy_cnt_q == 4'd0) begin
                        state_q     <= S_IDLE;
                        res_data_q  <= data_out;
                        res_valid_q <= 1'b1;
                    end else begin
                        busy_cnt_q <= busy_cnt_q - 4'd1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ce        = ce_q;
    assign load      = load_q;
    assign opcode    = opcode_q;
    assign data_in   = data_in_q;
    assign cin       = cin_q;
    assign cout      = cout_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

`ifdef ALU_CMD_STATS_EN
    logic [CNT_W-1:0] load_cnt_q;
    logic [CNT_W-1:0] exec_cnt_q;

    // One count per strobe cycle; stat_clr wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            load_cnt_q <= '0;
            exec_cnt_q <= '0;
        end else begin
            if (state_q == S_DRV_LOAD && load_cnt_q != '1) begin
                load_cnt_q <= load_cnt_q + CNT_W'(1);
            end
            if (state_q == S_DRV_EXEC && exec_cnt_q != '1) begin
                exec_cnt_q <= exec_cnt_q + CNT_W'(1);
            end
        end
    end

    assign load_cnt = load_cnt_q;
    assign exec_cnt = exec_cnt_q;
`endif

endmodule

// File: tb/tb_alu_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_master
//
// Self-checking bench for alu_cmd_master. Directed scenarios check the fixed
// values of the command/result protocol; a randomized run compares every
// cycle against a transaction-level reference model (accept times, busy
// window, result pickup) kept in the bench. data_out is driven with a fresh
// random byte every cycle and logged, so the expected result of an execute
// is simply the logged byte of the last busy cycle.
// -----------------------------------------------------------------------------
module tb_alu_cmd_master;

    localparam int B     = 2;
    localparam int CNT_W = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_exec = 1'b0;
    logic [2:0] cmd_reg = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic [3:0] cmd_op = 4'h0;
    logic       cmd_cin = 1'b0;
    logic       cmd_cout = 1'b0;
    logic       ce;
    logic       load;
    logic [7:0] opcode;
    logic [7:0] data_in;
    logic       cin;
    logic       cout;
    logic [7:0] data_out;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
`ifdef ALU_CMD_STATS_EN
    logic             stat_clr = 1'b0;
    logic [CNT_W-1:0] load_cnt;
    logic [CNT_W-1:0] exec_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    alu_cmd_master #(.BUSY_CYCLES(B), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ALU_CMD_STATS_EN
        .stat_clr  (stat_clr),
        .load_cnt  (load_cnt),
        .exec_cnt  (exec_cnt),
`endif
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_exec  (cmd_exec),
        .cmd_reg   (cmd_reg),
        .cmd_data  (cmd_data),
        .cmd_op    (cmd_op),
        .cmd_cin   (cmd_cin),
        .cmd_cout  (cmd_cout),
        .ce        (ce),
        .load      (load),
        .opcode    (opcode),
        .data_in   (data_in),
        .cin       (cin),
        .cout      (cout),
        .data_out  (data_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // CPU stand-in: a new data_out byte each cycle, logged by cycle number.
    logic       dout_force_en  = 1'b0;
    logic [7:0] dout_force_val = 8'h00;
    logic [7:0] dlog [int];

    always @(posedge clk) begin
        #2;
        data_out  = dout_force_en ? dout_force_val : 8'($urandom);
        dlog[cyc] = data_out;
    end

    // ---------------- reference model ----------------
    bit         m_ready     = 1'b0;
    bit         m_ce        = 1'b0;
    bit         m_load      = 1'b0;
    logic [7:0] m_opcode    = 8'h00;
    logic [7:0] m_data_in   = 8'h00;
    bit         m_cin       = 1'b0;
    bit         m_cout      = 1'b0;
    bit         m_res_valid = 1'b0;
    logic [7:0] m_res_data  = 8'h00;
    int         exec_acc    = -1000;   // cycle in which the last execute was accepted

    // Advance one clock (sampling point is 1 time unit after the edge) and
    // update the model from the inputs that were applied during the cycle.
    task automatic step();
        bit         acc, hs, rs, ex, ci, co;
        logic [2:0] r;
        logic [7:0] d;
        logic [3:0] op;
        int         t;
        rs = rst;
        acc = cmd_valid && m_ready;
        hs  = m_res_valid && res_ready;
        ex = cmd_exec; r = cmd_reg; d = cmd_data; op = cmd_op; ci = cmd_cin; co = cmd_cout;
        @(posedge clk);
        #1;
        t = cyc;
        if (rs) begin
            m_ce = 0; m_load = 0; m_opcode = 8'h00; m_data_in = 8'h00;
            m_cin = 0; m_cout = 0; m_res_valid = 0; m_res_data = 8'h00;
            exec_acc = -1000;
        end else begin
            m_ce = acc;
            if (acc) begin
                m_load = !ex;
                if (ex) begin
                    m_opcode = {1'b0, r, op};
                    m_cin    = ci;
                    m_cout   = co;
                    exec_acc = t - 1;
                end else begin
                    m_opcode  = {1'b0, r, 4'h0};
                    m_data_in = d;
                end
            end
            if (hs) m_res_valid = 0;
            if (t == exec_acc + 2 + B) begin
                m_res_valid = 1;
                m_res_data  = dlog[t - 1];
            end
        end
        m_ready = !m_res_valid && !(t >= exec_acc + 1 && t <= exec_acc + 1 + B);
    endtask

    task automatic drive_cmd(input bit ex, input logic [2:0] r, input logic [7:0] d,
                             input logic [3:0] op, input bit ci, input bit co);
        cmd_valid = 1'b1; cmd_exec = ex; cmd_reg = r; cmd_data = d;
        cmd_op = op; cmd_cin = ci; cmd_cout = co;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int seen;
        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        checks++; if (ce !== 1'b0) begin failures++; $display("FAIL reset_ce: got %b expected 0", ce); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        checks++; if ({opcode, data_in, res_data} !== 24'h0) begin failures++;
            $display("FAIL reset_data: got op=%h din=%h res=%h expected all 00", opcode, data_in, res_data); end
        checks++; if ({load, cin, cout} !== 3'b000) begin failures++;
            $display("FAIL reset_ctrl: got load/cin/cout=%b expected 000", {load, cin, cout}); end

        // Reset in the middle of an execute's busy window.
        drive_cmd(1'b1, 3'd3, 8'h00, 4'h5, 1'b1, 1'b1);
        step();
        cmd_valid = 1'b0;
        step();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++; if (ce !== 1'b0) begin failures++; $display("FAIL midreset_ce: got %b expected 0", ce); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL midreset_res_valid: got %b expected 0", res_valid); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL midreset_cmd_ready: got %b expected 1", cmd_ready); end
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (res_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midreset_aborted_result: res_valid seen %0d cycles expected 0", seen); end
    endtask

    task automatic test_loads();
        logic [7:0] dat [3];
        logic [7:0] opc [3];
        dat[0] = 8'h12; dat[1] = 8'h34; dat[2] = 8'h56;
        opc[0] = 8'h10; opc[1] = 8'h20; opc[2] = 8'h30;
        for (int i = 0; i < 3; i++) begin
            drive_cmd(1'b0, 3'(i + 1), dat[i], 4'($urandom), 1'b0, 1'b0);
            step();
            checks++; if ({ce, load} !== 2'b11) begin failures++;
                $display("FAIL loads_strobe[%0d]: got ce/load=%b expected 11", i, {ce, load}); end
            checks++; if (opcode !== opc[i]) begin failures++;
                $display("FAIL loads_opcode[%0d]: got %h expected %h", i, opcode, opc[i]); end
            checks++; if (data_in !== dat[i]) begin failures++;
                $display("FAIL loads_data_in[%0d]: got %h expected %h", i, data_in, dat[i]); end
        end
        cmd_valid = 1'b0;
        step();
        checks++; if (ce !== 1'b0) begin failures++; $display("FAIL loads_end_ce: got %b expected 0", ce); end
        checks++; if (data_in !== 8'h56) begin failures++; $display("FAIL loads_data_hold: got %h expected 56", data_in); end
    endtask

    task automatic test_exec();
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL exec_ready_a: got %b expected 1", cmd_ready); end
        drive_cmd(1'b1, 3'd2, 8'($urandom), 4'h1, 1'b1, 1'b0);
        step();   // a+1
        cmd_valid = 1'b0;
        checks++; if ({ce, load} !== 2'b10) begin failures++; $display("FAIL exec_strobe: got ce/load=%b expected 10", {ce, load}); end
        checks++; if (opcode !== 8'h21) begin failures++; $display("FAIL exec_opcode: got %h expected 21", opcode); end
        checks++; if ({cin, cout} !== 2'b10) begin failures++; $display("FAIL exec_cin_cout: got %b expected 10", {cin, cout}); end
        checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL exec_ready_a1: got %b expected 0", cmd_ready); end
        step();   // a+2
        checks++; if ({ce, cmd_ready} !== 2'b00) begin failures++; $display("FAIL exec_busy: got ce/ready=%b expected 00", {ce, cmd_ready}); end
        dout_force_val = 8'hA5;
        dout_force_en  = 1'b1;
        step();   // a+3
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL exec_early_valid: got %b expected 0", res_valid); end
        step();   // a+4
        dout_force_en = 1'b0;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL exec_res_valid: got %b expected 1", res_valid); end
        checks++; if (res_data !== 8'hA5) begin failures++; $display("FAIL exec_res_data: got %h expected a5", res_data); end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++; if ({res_valid, cmd_ready} !== 2'b01) begin failures++;
            $display("FAIL exec_consume: got valid/ready=%b expected 01", {res_valid, cmd_ready}); end
    endtask

    task automatic test_backpressure();
        int t_ce;
        drive_cmd(1'b1, 3'($urandom), 8'h00, 4'($urandom), 1'($urandom), 1'($urandom));
        step();
        t_ce = cyc;
        drive_cmd(1'b0, 3'd5, 8'h77, 4'h0, 1'b0, 1'b0);   // load waits behind the result
        for (int k = 0; k < 20 && res_valid !== 1'b1; k++) step();
        checks++; if (res_valid !== 1'b1 || cyc != t_ce + B + 1) begin failures++;
            $display("FAIL bp_res_time: got valid=%b at +%0d expected 1 at +%0d", res_valid, cyc - t_ce, B + 1); end
        for (int k = 0; k < 5; k++) begin
            checks++; if ({res_valid, cmd_ready, ce} !== 3'b100 || res_data !== dlog[t_ce + B]) begin failures++;
                $display("FAIL bp_hold[%0d]: got valid/ready/ce=%b data=%h expected 100 data=%h",
                         k, {res_valid, cmd_ready, ce}, res_data, dlog[t_ce + B]); end
            step();
        end
        res_ready = 1'b1;
        step();
        checks++; if ({res_valid, cmd_ready} !== 2'b01) begin failures++;
            $display("FAIL bp_release: got valid/ready=%b expected 01", {res_valid, cmd_ready}); end
        res_ready = 1'b0;
        step();
        cmd_valid = 1'b0;
        checks++; if ({ce, load, data_in} !== {2'b11, 8'h77}) begin failures++;
            $display("FAIL bp_stalled_load: got ce/load=%b din=%h expected 11 77", {ce, load}, data_in); end
        step();
    endtask

    task automatic test_load_exec();
        int t_e;
        drive_cmd(1'b0, 3'd4, 8'h9C, 4'h0, 1'b0, 1'b0);
        step();
        checks++; if ({ce, load} !== 2'b11) begin failures++; $display("FAIL ldex_load: got ce/load=%b expected 11", {ce, load}); end
        drive_cmd(1'b1, 3'd0, 8'h00, 4'hF, 1'b0, 1'b1);    // reg 0 is a legal operand B
        step();
        t_e = cyc;
        checks++; if ({ce, load, opcode} !== {2'b10, 8'h0F}) begin failures++;
            $display("FAIL ldex_exec: got ce/load=%b op=%h expected 10 0f", {ce, load}, opcode); end
        drive_cmd(1'b0, 3'd1, 8'h01, 4'h0, 1'b0, 1'b0);
        res_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            step();
            if (ce === 1'b1) break;
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        checks++; if (ce !== 1'b1 || cyc - t_e < B + 2) begin failures++;
            $display("FAIL ldex_spacing: got ce=%b gap=%0d expected ce=1 gap>=%0d", ce, cyc - t_e, B + 2); end
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            checks++; if (cmd_ready !== m_ready) begin failures++;
                $display("FAIL rnd_cmd_ready @%0d: got %b expected %b", cyc, cmd_ready, m_ready); end
            checks++; if (ce !== m_ce) begin failures++;
                $display("FAIL rnd_ce @%0d: got %b expected %b", cyc, ce, m_ce); end
            if (m_ce) begin
                checks++; if (load !== m_load || opcode !== m_opcode) begin failures++;
                    $display("FAIL rnd_strobe @%0d: got load=%b op=%h expected load=%b op=%h",
                             cyc, load, opcode, m_load, m_opcode); end
            end
            checks++; if (opcode[7] !== 1'b0) begin failures++;
                $display("FAIL rnd_opcode7 @%0d: got %b expected 0", cyc, opcode[7]); end
            checks++; if (data_in !== m_data_in || cin !== m_cin || cout !== m_cout) begin failures++;
                $display("FAIL rnd_operands @%0d: got din=%h cin=%b cout=%b expected din=%h cin=%b cout=%b",
                         cyc, data_in, cin, cout, m_data_in, m_cin, m_cout); end
            checks++; if (res_valid !== m_res_valid) begin failures++;
                $display("FAIL rnd_res_valid @%0d: got %b expected %b", cyc, res_valid, m_res_valid); end
            if (m_res_valid) begin
                checks++; if (res_data !== m_res_data) begin failures++;
                    $display("FAIL rnd_res_data @%0d: got %h expected %h", cyc, res_data, m_res_data); end
            end
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) != 0)
                drive_cmd(1'($urandom), 3'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            else
                cmd_valid = 1'b0;
            res_ready = ($urandom_range(0, 2) == 0);
            step();
        end
        rst = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
        for (int k = 0; k < 10; k++) step();
        res_ready = 1'b0;
    endtask

`ifdef ALU_CMD_STATS_EN
    task automatic test_stats();
        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b1; stat_clr = 1'b0;
        step();
        rst = 1'b0;
        step();
        checks++; if (load_cnt !== '0 || exec_cnt !== '0) begin failures++;
            $display("FAIL stats_reset: got %0d/%0d expected 0/0", load_cnt, exec_cnt); end
        for (int i = 0; i < 2; i++) begin
            drive_cmd(1'b0, 3'(i), 8'($urandom), 4'h0, 1'b0, 1'b0);
            step();
        end
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            drive_cmd(1'b1, 3'($urandom), 8'h00, 4'($urandom), 1'b0, 1'b0);
            step();
            cmd_valid = 1'b0;
            for (int k = 0; k < 20; k++) begin
                step();
                if (cmd_ready === 1'b1) break;
            end
        end
        checks++; if (load_cnt !== CNT_W'(2) || exec_cnt !== CNT_W'(3)) begin failures++;
            $display("FAIL stats_counts: got %0d/%0d expected 2/3", load_cnt, exec_cnt); end
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        res_ready = 1'b0;
        checks++; if (load_cnt !== '0 || exec_cnt !== '0) begin failures++;
            $display("FAIL stats_clear: got %0d/%0d expected 0/0", load_cnt, exec_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_loads();
        test_exec();
        test_backpressure();
        test_load_exec();
        test_random();
`ifdef ALU_CMD_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
